// File: rtl/vector_addsub_axis.sv
`default_nettype none
// ============================================================================
//  Module   : vector_addsub_axis
//  Purpose  : Streaming AXI-Stream vector adder/subtractor. Each accepted
//             beat carries two N-element signed vectors A and B; the block
//             returns S = A+B (user=0) or S = A-B (user=1), one guard bit per
//             element, through a fixed PIPE-stage pipeline and a show-ahead
//             output FIFO. Credit-based input flow control guarantees that
//             every accepted beat has a FIFO slot waiting for it.
//  Ports    : clk, reset (async, active-high)
//             enable                    - gates new input acceptance only
//             s_axis_data/user/valid/ready - input beat {A0..AN-1,B0..BN-1}
//             m_axis_data/valid/ready   - result beat {S0..SN-1}
//             busy                      - beats in flight or buffered
//  Revision : 1.0 - initial release
// ============================================================================
module vector_addsub_axis #(
   parameter int N          = 11,
   parameter int W          = 10,
   parameter int PIPE       = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic [2*N*W-1:0]     s_axis_data,
   input  logic                 s_axis_user,
   input  logic                 s_axis_valid,
   output logic                 s_axis_ready,
   output logic [N*(W+1)-1:0]   m_axis_data,
   output logic                 m_axis_valid,
   input  logic                 m_axis_ready,
   output logic                 busy
);

   localparam int                 C_IN_W  = 2*N*W;
   localparam int                 C_OUT_W = N*(W+1);
   localparam int                 C_CNT_W = $clog2(FIFO_DEPTH+1);
   localparam int                 C_IDX_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [C_CNT_W-1:0] C_DEPTH = C_CNT_W'(FIFO_DEPTH);
   localparam logic [C_CNT_W-1:0] C_ONE   = C_CNT_W'(1);

   logic                 w_accept;
   logic                 w_push;
   logic                 w_pop;
   logic [C_OUT_W-1:0]   w_result;

   logic [C_OUT_W-1:0]   r_pipe_data [PIPE];
   logic [PIPE-1:0]      r_pipe_vld;

   logic [C_OUT_W-1:0]   r_mem      [FIFO_DEPTH];
   logic [C_OUT_W-1:0]   w_mem_next [FIFO_DEPTH];
   logic [C_CNT_W-1:0]   r_count;
   logic [C_CNT_W-1:0]   w_count_next;
   logic [C_CNT_W-1:0]   w_wr_pos;
   logic [C_IDX_W-1:0]   w_wr_idx;
   logic                 r_out_valid;

   logic [C_CNT_W-1:0]   r_occ;
   logic [C_CNT_W-1:0]   w_occ_next;

   // ------------------------------------------------------------------------
   // Flow control. Credits are counted from acceptance to pop, so a full
   // pipeline plus FIFO can never overflow. A pop on the same edge is not
   // credited, keeping ready a function of registered state. Reset is folded
   // in so ready is held low for the whole time reset is asserted.
   // ------------------------------------------------------------------------
   assign s_axis_ready = enable & ~reset & (r_occ < C_DEPTH);
   assign w_accept     = s_axis_valid & s_axis_ready;
   assign w_pop        = r_out_valid & m_axis_ready;
   assign w_push       = r_pipe_vld[PIPE-1];
   assign busy         = (r_occ != '0);

   // ------------------------------------------------------------------------
   // Element arithmetic: sign-extend both operands by one bit, so the sum or
   // difference is always exact in W+1 bits.
   // ------------------------------------------------------------------------
   genvar e;
   generate
      for (e = 0; e < N; e++) begin : g_elem
         logic [W:0] w_a;
         logic [W:0] w_b;
         assign w_a = {s_axis_data[C_IN_W-1-e*W], s_axis_data[C_IN_W-1-e*W -: W]};
         assign w_b = {s_axis_data[N*W-1-e*W],    s_axis_data[N*W-1-e*W -: W]};
         assign w_result[C_OUT_W-1-e*(W+1) -: (W+1)] = s_axis_user ? (w_a - w_b)
                                                                    : (w_a + w_b);
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Pipeline: the mode is consumed in the first stage, the remaining stages
   // carry the result and its valid bit. It never stalls; the credit rule
   // guarantees the FIFO has room when a beat falls out of the last stage.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pipe_vld <= '0;
         for (int i = 0; i < PIPE; i++) begin
            r_pipe_data[i] <= '0;
         end
      end else begin
         r_pipe_vld[0]  <= w_accept;
         r_pipe_data[0] <= w_result;
         for (int i = 1; i < PIPE; i++) begin
            r_pipe_vld[i]  <= r_pipe_vld[i-1];
            r_pipe_data[i] <= r_pipe_data[i-1];
         end
      end
   end

   // ------------------------------------------------------------------------
   // Output FIFO as a shift register: entry 0 is always the head, so
   // m_axis_data comes straight from a flop and holds while stalled. A pop
   // shifts everything down one slot; a simultaneous push lands in the slot
   // just vacated by the shift.
   // ------------------------------------------------------------------------
   assign w_wr_pos = w_pop ? (r_count - C_ONE) : r_count;
   assign w_wr_idx = w_wr_pos[C_IDX_W-1:0];

   always_comb begin
      for (int i = 0; i < FIFO_DEPTH-1; i++) begin
         w_mem_next[i] = w_pop ? r_mem[i+1] : r_mem[i];
      end
      w_mem_next[FIFO_DEPTH-1] = r_mem[FIFO_DEPTH-1];
      if (w_push) begin
         w_mem_next[w_wr_idx] = r_pipe_data[PIPE-1];
      end
   end

   always_comb begin
      w_count_next = r_count;
      if (w_push && !w_pop) begin
         w_count_next = r_count + C_ONE;
      end else if (!w_push && w_pop) begin
         w_count_next = r_count - C_ONE;
      end
   end

   always_comb begin
      w_occ_next = r_occ;
      if (w_accept && !w_pop) begin
         w_occ_next = r_occ + C_ONE;
      end else if (!w_accept && w_pop) begin
         w_occ_next = r_occ - C_ONE;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count     <= '0;
         r_occ       <= '0;
         r_out_valid <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         r_count     <= w_count_next;
         r_occ       <= w_occ_next;
         r_out_valid <= (w_count_next != '0);
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_mem[i] <= w_mem_next[i];
         end
      end
   end

   assign m_axis_data  = r_mem[0];
   assign m_axis_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_vector_addsub_axis.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vector_addsub_axis
//  Purpose  : Self-checking bench for vector_addsub_axis. A queue of expected
//             results (value plus acceptance cycle) is the reference model;
//             each scenario task drives stimulus and compares inline.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vector_addsub_axis;

   localparam int N    = 11;
   localparam int W    = 10;
   localparam int PIPE = 2;
   localparam int FD   = 4;
   localparam int DW   = 2*N*W;
   localparam int OW   = N*(W+1);

   logic          clk;
   logic          reset;
   logic          enable;
   logic [DW-1:0] s_axis_data;
   logic          s_axis_user;
   logic          s_axis_valid;
   logic          s_axis_ready;
   logic [OW-1:0] m_axis_data;
   logic          m_axis_valid;
   logic          m_axis_ready;
   logic          busy;

   vector_addsub_axis #(.N(N), .W(W), .PIPE(PIPE), .FIFO_DEPTH(FD)) dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .s_axis_data  (s_axis_data),
      .s_axis_user  (s_axis_user),
      .s_axis_valid (s_axis_valid),
      .s_axis_ready (s_axis_ready),
      .m_axis_data  (m_axis_data),
      .m_axis_valid (m_axis_valid),
      .m_axis_ready (m_axis_ready),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [OW-1:0] d;
      int            c;
   } exp_t;

   exp_t          exp_q[$];
   int            checks   = 0;
   int            failures = 0;
   int            cyc      = 0;

   // Observations of the last step (sampled just before its clock edge)
   logic          obs_acc, obs_pop, obs_rdy, obs_mv;
   logic [OW-1:0] obs_pd;
   int            obs_cyc;
   logic          exp_have;
   logic [OW-1:0] exp_d;
   int            exp_c;

   // Reference: element-wise signed integer add/subtract, kept to W+1 bits
   function automatic logic [OW-1:0] ref_model(input logic [DW-1:0] d, input logic u);
      logic [OW-1:0] r;
      logic [W-1:0]  ta, tb;
      int            a, b, s;
      r = '0;
      for (int k = 0; k < N; k++) begin
         ta = d[DW-1-k*W -: W];
         tb = d[N*W-1-k*W -: W];
         a  = int'($signed(ta));
         b  = int'($signed(tb));
         s  = u ? (a - b) : (a + b);
         r[OW-1-k*(W+1) -: (W+1)] = s[W:0];
      end
      return r;
   endfunction

   function automatic logic [DW-1:0] rand_vec();
      logic [DW-1:0] r;
      for (int k = 0; k < DW; k++) r[k] = 1'($urandom);
      return r;
   endfunction

   // One clock cycle: drive, sample before the edge, update the model.
   task automatic step(input logic v, input logic u, input logic [DW-1:0] d, input logic mr);
      exp_t e;
      s_axis_valid = v;
      s_axis_user  = u;
      s_axis_data  = d;
      m_axis_ready = mr;
      #1;
      obs_rdy  = s_axis_ready;
      obs_mv   = m_axis_valid;
      obs_pd   = m_axis_data;
      obs_cyc  = cyc;
      obs_acc  = v & s_axis_ready;
      obs_pop  = m_axis_valid & mr;
      exp_have = 1'b0;
      if (obs_pop && exp_q.size() > 0) begin
         e        = exp_q.pop_front();
         exp_have = 1'b1;
         exp_d    = e.d;
         exp_c    = e.c;
      end
      @(posedge clk);
      cyc++;
      if (obs_acc) exp_q.push_back('{ref_model(d, u), cyc});
      #1;
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if (s_axis_ready !== 1'b0 || m_axis_valid !== 1'b0 || busy !== 1'b0 || m_axis_data !== '0) begin
         failures++;
         $display("FAIL reset_state: ready=%b valid=%b busy=%b data=%h, required all zero",
                  s_axis_ready, m_axis_valid, busy, m_axis_data);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      checks++;
      if (s_axis_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_release_ready: got %b required 1", s_axis_ready);
      end
      enable = 1'b0;
      #1;
      checks++;
      if (s_axis_ready !== 1'b0) begin
         failures++;
         $display("FAIL reset_enable_low_ready: got %b required 0", s_axis_ready);
      end
      enable = 1'b1;
   endtask

   task automatic test_add();
      logic [DW-1:0] d;
      logic          got;
      d = rand_vec();
      d[DW-1 -: W]      = 10'h1FF;   // A0  =  511
      d[N*W+W-1 -: W]   = 10'h200;   // A10 = -512
      d[N*W-1 -: W]     = 10'h1FF;   // B0  =  511
      d[W-1:0]          = 10'h200;   // B10 = -512
      step(1'b1, 1'b0, d, 1'b1);
      checks++;
      if (obs_acc !== 1'b1) begin
         failures++;
         $display("FAIL add_accept: accept=%b required 1", obs_acc);
      end
      got = 1'b0;
      for (int t = 0; t < 10 && !got; t++) begin
         step(1'b0, 1'b0, '0, 1'b1);
         if (obs_pop) begin
            got = 1'b1;
            checks++;
            if (!exp_have || obs_pd !== exp_d) begin
               failures++;
               $display("FAIL add_data: got %h expected %h", obs_pd, exp_d);
            end
            checks++;
            if (obs_pd[OW-1 -: 11] !== 11'h3FE || obs_pd[10:0] !== 11'h400) begin
               failures++;
               $display("FAIL add_s0_s10: got S0=%h S10=%h required 3fe 400",
                        obs_pd[OW-1 -: 11], obs_pd[10:0]);
            end
            checks++;
            if (obs_cyc != exp_c + PIPE) begin
               failures++;
               $display("FAIL add_latency: got %0d cycles required %0d", obs_cyc - exp_c, PIPE);
            end
         end
      end
      if (!got) begin
         checks++;
         failures++;
         $display("FAIL add_timeout: valid=0 required a result");
      end
   endtask

   task automatic test_sub();
      logic [DW-1:0] d;
      int            n_out;
      logic [10:0]   s0_req [2];
      s0_req[0] = 11'h401;
      s0_req[1] = 11'h7FF;
      d = rand_vec();
      d[DW-1 -: W]  = 10'h200;   // A0 = -512
      d[N*W-1 -: W] = 10'h1FF;   // B0 =  511
      step(1'b1, 1'b1, d, 1'b1);
      step(1'b1, 1'b0, d, 1'b1);
      n_out = 0;
      for (int t = 0; t < 10 && n_out < 2; t++) begin
         step(1'b0, 1'b0, '0, 1'b1);
         if (obs_pop) begin
            checks++;
            if (!exp_have || obs_pd !== exp_d || obs_pd[OW-1 -: 11] !== s0_req[n_out]) begin
               failures++;
               $display("FAIL sub_beat%0d: got %h (S0=%h) required S0=%h",
                        n_out, obs_pd, obs_pd[OW-1 -: 11], s0_req[n_out]);
            end
            n_out++;
         end
      end
      checks++;
      if (n_out != 2) begin
         failures++;
         $display("FAIL sub_count: got %0d results required 2", n_out);
      end
   endtask

   task automatic test_stream();
      int n_out;
      n_out = 0;
      for (int t = 0; t < 30 && (t < 20 || exp_q.size() > 0); t++) begin
         step(t < 20, 1'($urandom), rand_vec(), 1'b1);
         if (t < 20) begin
            checks++;
            if (obs_rdy !== 1'b1) begin
               failures++;
               $display("FAIL stream_ready: beat %0d ready=%b required 1", t, obs_rdy);
            end
         end
         if (obs_pop) begin
            n_out++;
            checks++;
            if (!exp_have || obs_pd !== exp_d) begin
               failures++;
               $display("FAIL stream_data: got %h expected %h", obs_pd, exp_d);
            end else if (obs_cyc != exp_c + PIPE) begin
               failures++;
               $display("FAIL stream_latency: got %0d cycles required %0d", obs_cyc - exp_c, PIPE);
            end
         end
      end
      checks++;
      if (n_out != 20) begin
         failures++;
         $display("FAIL stream_count: got %0d results required 20", n_out);
      end
   endtask

   task automatic test_backpressure();
      logic [DW-1:0] d;
      logic          u;
      int            n_acc, n_out;
      logic          prev_pop, first;
      n_acc = 0;
      d = rand_vec();
      u = 1'($urandom);
      for (int i = 0; i < 6; i++) begin
         step(1'b1, u, d, 1'b0);
         if (obs_acc) begin
            n_acc++;
            d = rand_vec();
            u = 1'($urandom);
         end
      end
      checks++;
      if (n_acc != FD) begin
         failures++;
         $display("FAIL bp_accept_count: got %0d required %0d", n_acc, FD);
      end
      for (int i = 0; i < 4; i++) begin
         step(1'b1, u, d, 1'b0);
         checks++;
         if (obs_rdy !== 1'b0 || obs_acc !== 1'b0) begin
            failures++;
            $display("FAIL bp_ready_low: ready=%b required 0", obs_rdy);
         end
         if (obs_mv && exp_q.size() > 0) begin
            checks++;
            if (obs_pd !== exp_q[0].d) begin
               failures++;
               $display("FAIL bp_stable: got %h required %h", obs_pd, exp_q[0].d);
            end
         end
      end
      n_out    = 0;
      prev_pop = 1'b0;
      first    = 1'b1;
      for (int t = 0; t < 12 && (exp_q.size() > 0 || prev_pop); t++) begin
         step(1'b0, 1'b0, '0, 1'b1);
         if (prev_pop) begin
            checks++;
            if (obs_rdy !== 1'b1) begin
               failures++;
               $display("FAIL bp_ready_after_pop: ready=%b required 1", obs_rdy);
            end
         end
         if (obs_pop && first) begin
            first = 1'b0;
            checks++;
            if (obs_rdy !== 1'b0) begin
               failures++;
               $display("FAIL bp_ready_same_pop: ready=%b required 0", obs_rdy);
            end
         end
         if (obs_pop) begin
            n_out++;
            checks++;
            if (!exp_have || obs_pd !== exp_d) begin
               failures++;
               $display("FAIL bp_data: got %h expected %h", obs_pd, exp_d);
            end
         end
         prev_pop = obs_pop;
      end
      checks++;
      if (n_out != FD) begin
         failures++;
         $display("FAIL bp_drain_count: got %0d required %0d", n_out, FD);
      end
   endtask

   task automatic test_enable();
      step(1'b1, 1'($urandom), rand_vec(), 1'b1);
      step(1'b1, 1'($urandom), rand_vec(), 1'b1);
      enable = 1'b0;
      for (int t = 0; t < 8; t++) begin
         step(1'b1, 1'($urandom), rand_vec(), 1'b1);
         checks++;
         if (obs_acc !== 1'b0) begin
            failures++;
            $display("FAIL en_no_accept: ready=%b required 0", obs_rdy);
         end
         if (obs_pop) begin
            checks++;
            if (!exp_have || obs_pd !== exp_d) begin
               failures++;
               $display("FAIL en_data: got %h expected %h", obs_pd, exp_d);
            end
         end
         checks++;
         if (busy !== (exp_q.size() != 0)) begin
            failures++;
            $display("FAIL en_busy: got %b required %b", busy, exp_q.size() != 0);
         end
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL en_delivered: %0d results outstanding required 0", exp_q.size());
      end
      enable = 1'b1;
   endtask

   task automatic test_random();
      logic exp_rdy, exp_mv;
      for (int t = 0; t < 320; t++) begin
         if (t < 300) enable = ($urandom_range(0, 9) != 0);
         else         enable = 1'b1;
         exp_rdy = enable && (exp_q.size() < FD);
         exp_mv  = (exp_q.size() > 0) && (cyc >= exp_q[0].c + PIPE);
         step((t < 300) && ($urandom_range(0, 9) < 7), 1'($urandom), rand_vec(),
              (t >= 300) || ($urandom_range(0, 9) < 6));
         checks++;
         if (obs_rdy !== exp_rdy || obs_mv !== exp_mv) begin
            failures++;
            $display("FAIL rand_flags: cycle %0d ready=%b valid=%b required %b %b",
                     t, obs_rdy, obs_mv, exp_rdy, exp_mv);
         end
         if (obs_pop) begin
            checks++;
            if (!exp_have || obs_pd !== exp_d) begin
               failures++;
               $display("FAIL rand_data: cycle %0d got %h expected %h", t, obs_pd, exp_d);
            end
         end
         checks++;
         if (busy !== (exp_q.size() != 0)) begin
            failures++;
            $display("FAIL rand_busy: cycle %0d got %b required %b", t, busy, exp_q.size() != 0);
         end
      end
   endtask

   task automatic test_reset_mid();
      int n_acc;
      logic got;
      n_acc = 0;
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'($urandom), rand_vec(), 1'b0);
         if (obs_acc) n_acc++;
      end
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b0);
      checks++;
      if (n_acc != 3 || m_axis_valid !== 1'b1) begin
         failures++;
         $display("FAIL rst_setup: accepted %0d valid=%b required 3 1", n_acc, m_axis_valid);
      end
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (m_axis_valid !== 1'b0 || busy !== 1'b0 || s_axis_ready !== 1'b0 || m_axis_data !== '0) begin
         failures++;
         $display("FAIL rst_immediate: valid=%b busy=%b ready=%b data=%h required all zero",
                  m_axis_valid, busy, s_axis_ready, m_axis_data);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      exp_q.delete();
      for (int t = 0; t < 6; t++) begin
         step(1'b0, 1'b0, '0, 1'b1);
         checks++;
         if (obs_mv !== 1'b0) begin
            failures++;
            $display("FAIL rst_stale: valid=%b data=%h required no output", obs_mv, obs_pd);
         end
      end
      step(1'b1, 1'($urandom), rand_vec(), 1'b1);
      got = 1'b0;
      for (int t = 0; t < 8 && !got; t++) begin
         step(1'b0, 1'b0, '0, 1'b1);
         if (obs_pop) begin
            got = 1'b1;
            checks++;
            if (!exp_have || obs_pd !== exp_d) begin
               failures++;
               $display("FAIL rst_after_data: got %h expected %h", obs_pd, exp_d);
            end
         end
      end
      if (!got) begin
         checks++;
         failures++;
         $display("FAIL rst_after_timeout: no result after reset");
      end
   endtask

   initial begin
      reset        = 1'b1;
      enable       = 1'b1;
      s_axis_data  = '0;
      s_axis_user  = 1'b0;
      s_axis_valid = 1'b0;
      m_axis_ready = 1'b0;
      test_reset();
      test_add();
      test_sub();
      test_stream();
      test_backpressure();
      test_enable();
      test_random();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire

// File: doc/vector_addsub_axis.md
# vector_addsub_axis

Parametrised AXI-Stream vector adder/subtractor: each accepted input beat carries two N-element signed vectors A and B, and the block produces one N-element result vector S = A±B with one guard bit per element. It is the streaming-throughput successor of the single-shot vector-add wrappers in the linear-algebra layer. It accepts one beat per clock through a fixed-latency adder pipeline and an output FIFO. Credit-based input flow control guarantees no result is dropped under downstream backpressure.

## Interface
- N, 11, number of vector elements (≥1)
- W, 10, input element width in bits, signed two's complement (≥2)
- PIPE, 2, adder pipeline depth in clock edges (≥1)
- FIFO_DEPTH, 4, output FIFO entries, power of two, must satisfy FIFO_DEPTH ≥ PIPE+2
- clk  in  1  single clock; everything is sampled on the rising edge
- reset  in  1  asynchronous, active-high; clears all state
- enable  in  1  when low, blocks new input acceptance only
- s_axis_data  in  2·N·W  packed {A0..A(N-1), B0..B(N-1)}; A0 occupies the MSBs, B(N-1) the LSBs
- s_axis_user  in  1  mode for this beat: 0 = add (A+B), 1 = subtract (A−B)
- s_axis_valid  in  1  input beat valid
- s_axis_ready  out  1  input ready
- m_axis_data  out  N·(W+1)  packed {S0..S(N-1)}; S0 occupies the MSBs
- m_axis_valid  out  1  output beat valid
- m_axis_ready  in  1  downstream ready
- busy  out  1  high while any beat is in flight or held in the FIFO

## Operation
- Arithmetic: each operand is sign-extended to W+1 bits, then added or subtracted. The result is exact; no saturation and no wrap is possible.
- Mode is sampled together with the data on acceptance (s_axis_valid & s_axis_ready) and travels down the pipeline with that beat.
- Pipeline: PIPE register stages, each with a valid bit. A beat is always written into the FIFO PIPE edges after acceptance; the pipeline never stalls.
- Occupancy counter: the number of in-flight beats plus FIFO entries, range 0..FIFO_DEPTH. It increments on accept, decrements on pop (m_axis_valid & m_axis_ready), and is unchanged when both happen on the same edge.
- s_axis_ready = enable & (occupancy < FIFO_DEPTH). This is a combinational function of registered state only. It is conservative: a pop on the same edge is not credited.
- FIFO: show-ahead. m_axis_data = head entry and m_axis_valid = FIFO non-empty, both driven directly from registers.
- Ordering: results leave in acceptance order. A simultaneous push and pop is legal in every state, including when the FIFO is full. A push into a full FIFO cannot occur because of the credit rule.
- AXI rules: while m_axis_valid=1 and m_axis_ready=0, m_axis_data holds stable. m_axis_valid never depends combinationally on m_axis_ready.
- enable low: no new beats are accepted. In-flight beats still complete and the FIFO still drains.
- busy = (occupancy ≠ 0).

## Timing
- Reset values: s_axis_ready=0 while reset is asserted, then equals enable on the first cycle after reset deasserts. m_axis_valid=0, m_axis_data=0, busy=0, all pipeline valid bits 0, FIFO empty.
- Latency: a beat accepted on edge k makes m_axis_valid high in the cycle after edge k+PIPE, i.e. PIPE cycles of latency.
- Throughput: 1 beat/clock sustained when m_axis_ready is held high.
- Backpressure: with m_axis_ready=0 the block accepts exactly FIFO_DEPTH beats, then drops s_axis_ready. Each pop frees one credit, and s_axis_ready rises in the cycle after the pop edge.
- Reset mid-operation: all in-flight and buffered beats are discarded and m_axis_valid falls immediately (asynchronous). No partial beat appears after reset deasserts.

## Test plan
- Add, N=11, W=10: A0=511, B0=511, A10=−512, B10=−512, mode=0 -> S0=1022 (11'h3FE), S10=−1024 (11'h400), 2 cycles after accept.
- Subtract: A0=−512, B0=511, mode=1 -> S0=−1023 (11'h401). A following beat with mode=0 and the same data -> S0=−1 (11'h7FF), with per-beat mode honoured.
- Streaming: 20 back-to-back beats with m_axis_ready=1 -> s_axis_ready stays 1, outputs arrive in order, each 2 cycles after its accept, one per clock.
- Backpressure: m_axis_ready=0 with 6 beats offered -> exactly 4 accepted, s_axis_ready=0, m_axis_data stable. Release -> 4 results in order, with ready reasserting one cycle after each pop.
- enable=0 with 2 beats in flight -> no new accepts, both results still delivered, busy falls after the last pop.
- reset pulsed for 1 cycle with 3 beats buffered -> m_axis_valid=0 at once, busy=0, and no stale outputs afterwards.
